inst_cache_ctrl: RTL and testbench

Responder side of the instruction-fetch interface. Accepts a word-addressed fetch request (`ptr`, `fetch_enable`) from the fetch stage and serves it from a direct-mapped, one-word-per-line instruction cache. On a miss it refills from backing instruction memory over a req/ack handshake. It holds `busy` high until the word is delivered and counts misses in a register, so the fetch stage needs no simulation-only reporting.

---
 rtl/inst_cache_ctrl_pkg.sv | 11 +
 rtl/inst_cache_array.sv | 52 +++++
 rtl/inst_cache_ctrl.sv | 145 ++++++++++++++
 tb/tb_inst_cache_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_cache_ctrl_pkg.sv
// Shared parameters and state encoding for the instruction cache controller.
package inst_cache_ctrl_pkg;

    localparam int unsigned WORD_SIZE = 32;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_e;

endpackage

// File: rtl/inst_cache_array.sv
// Direct-mapped one-word-per-line storage: combinational read, one synchronous
// write port and a bulk clear of the valid bits.
module inst_cache_array #(
    parameter int unsigned WORD_SIZE = inst_cache_ctrl_pkg::WORD_SIZE,
    parameter int unsigned LINES     = 16,
    localparam int unsigned IDX_W    = $clog2(LINES),
    localparam int unsigned TAG_W    = WORD_SIZE - IDX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     i_rd_idx,
    output logic                 o_rd_valid,
    output logic [TAG_W-1:0]     o_rd_tag,
    output logic [WORD_SIZE-1:0] o_rd_data,
    input  logic                 i_wr_en,
    input  logic [IDX_W-1:0]     i_wr_idx,
    input  logic [TAG_W-1:0]     i_wr_tag,
    input  logic [WORD_SIZE-1:0] i_wr_data,
    input  logic                 i_wr_valid,
    input  logic                 i_clear
);

    logic [LINES-1:0]     r_valid;
    logic [TAG_W-1:0]     r_tag  [LINES];
    logic [WORD_SIZE-1:0] r_data [LINES];

    // Only the valid bits need a reset; tag/data are qualified by them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            if (i_clear) begin
                r_valid <= '0;
            end
            if (i_wr_en) begin
                r_valid[i_wr_idx] <= i_wr_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/inst_cache_ctrl.sv
// Instruction-fetch responder: serves word fetches from a direct-mapped cache
// and refills misses from backing memory over a req/ack handshake.
module inst_cache_ctrl #(
    parameter int unsigned WORD_SIZE = inst_cache_ctrl_pkg::WORD_SIZE,
    parameter int unsigned LINES     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_enable,
    input  logic [WORD_SIZE-1:0] ptr,
    input  logic                 flush,
    output logic [WORD_SIZE-1:0] out,
    output logic                 valid,
    output logic                 hit,
    output logic                 busy,
    output logic                 mem_req,
    output logic [WORD_SIZE-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_data,
    output logic [WORD_SIZE-1:0] miss_count
);

    import inst_cache_ctrl_pkg::*;

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = WORD_SIZE - IDX_W;

    state_e               r_state, w_state_nxt;
    logic [WORD_SIZE-1:0] r_out, w_out_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_hit, w_hit_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_req, w_req_nxt;
    logic [WORD_SIZE-1:0] r_addr, w_addr_nxt;
    logic [WORD_SIZE-1:0] r_cnt, w_cnt_nxt;

    logic                 w_rd_valid;
    logic [TAG_W-1:0]     w_rd_tag;
    logic [WORD_SIZE-1:0] w_rd_data;
    logic                 w_wr_en;
    logic                 w_wr_valid;
    logic                 w_clear;
    logic                 w_lookup_hit;

    inst_cache_array #(
        .WORD_SIZE (WORD_SIZE),
        .LINES     (LINES)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (ptr[IDX_W-1:0]),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (r_addr[IDX_W-1:0]),
        .i_wr_tag   (r_addr[WORD_SIZE-1:IDX_W]),
        .i_wr_data  (mem_data),
        .i_wr_valid (w_wr_valid),
        .i_clear    (w_clear)
    );

    // A concurrent flush forces the lookup to miss.
    assign w_lookup_hit = w_rd_valid && (w_rd_tag == ptr[WORD_SIZE-1:IDX_W]) && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_hit   <= 1'b0;
            r_busy  <= 1'b0;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_valid <= w_valid_nxt;
            r_hit   <= w_hit_nxt;
            r_busy  <= w_busy_nxt;
            r_req   <= w_req_nxt;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_valid_nxt = 1'b0;
        w_hit_nxt   = 1'b0;
        w_busy_nxt  = r_busy;
        w_req_nxt   = r_req;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_wr_en     = 1'b0;
        w_wr_valid  = 1'b0;
        w_clear     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_clear = flush;
                if (fetch_enable) begin
                    if (w_lookup_hit) begin
                        w_out_nxt   = w_rd_data;
                        w_hit_nxt   = 1'b1;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_addr_nxt  = ptr;
                        w_busy_nxt  = 1'b1;
                        w_req_nxt   = 1'b1;
                        w_cnt_nxt   = r_cnt + WORD_SIZE'(1);
                        w_state_nxt = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                // Flush on the ack edge still delivers the word but leaves the line invalid.
                if (mem_ack) begin
                    w_wr_en     = 1'b1;
                    w_wr_valid  = !flush;
                    w_clear     = flush;
                    w_out_nxt   = mem_data;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign out        = r_out;
    assign valid      = r_valid;
    assign hit        = r_hit;
    assign busy       = r_busy;
    assign mem_req    = r_req;
    assign mem_addr   = r_addr;
    assign miss_count = r_cnt;

endmodule

// File: tb/tb_inst_cache_ctrl.sv
// Scoreboard bench for inst_cache_ctrl: stimulus queues expected deliveries,
// a negedge monitor pops and compares on every valid pulse.
module tb_inst_cache_ctrl;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         fetch_enable;
    logic [W-1:0] ptr;
    logic         flush;
    logic [W-1:0] out;
    logic         valid;
    logic         hit;
    logic         busy;
    logic         mem_req;
    logic [W-1:0] mem_addr;
    logic         mem_ack;
    logic [W-1:0] mem_data;
    logic [W-1:0] miss_count;

    typedef struct packed {
        logic [W-1:0] data;
        logic         hit;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    inst_cache_ctrl #(.WORD_SIZE(W), .LINES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_enable (fetch_enable),
        .ptr          (ptr),
        .flush        (flush),
        .out          (out),
        .valid        (valid),
        .hit          (hit),
        .busy         (busy),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Backing memory contents
    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_hit(input logic [W-1:0] a, input logic [W-1:0] exp, input logic [W-1:0] exp_cnt);
        fetch_enable = 1'b1;
        ptr          = a;
        q.push_back('{data: exp, hit: 1'b1});
        step();
        fetch_enable = 1'b0;
        chk("hit_no_req", W'({busy, mem_req}), W'(0));
        chk("hit_miss_count", miss_count, exp_cnt);
    endtask

    // delay = number of cycles mem_req is high before ack is sampled
    task automatic do_miss(input logic [W-1:0] a, input logic [W-1:0] exp, input int delay,
                           input logic flush_req, input logic flush_ack, input logic [W-1:0] exp_cnt);
        fetch_enable = 1'b1;
        flush        = flush_req;
        ptr          = a;
        q.push_back('{data: exp, hit: 1'b0});
        step();
        fetch_enable = 1'b0;
        flush        = 1'b0;
        chk("miss_busy_req", W'({busy, mem_req}), W'(3));
        chk("miss_mem_addr", mem_addr, a);
        chk("miss_count", miss_count, exp_cnt);
        for (int i = 0; i < delay - 1; i++) begin
            step();
            chk("busy_hold", W'({busy, mem_req}), W'(3));
        end
        mem_ack  = 1'b1;
        mem_data = mem_word(a);
        flush    = flush_ack;
        step();
        mem_ack  = 1'b0;
        mem_data = '0;
        flush    = 1'b0;
        chk("busy_drop", W'({busy, mem_req}), W'(0));
    endtask

    always @(negedge clk) begin
        if (!rst && valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_valid: got out=0x%08h hit=%0b expected no delivery at %0t", out, hit, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("deliver_out", out, e.data);
                chk("deliver_hit", W'(hit), W'(e.hit));
            end
        end
    end

    initial begin
        rst          = 1'b1;
        fetch_enable = 1'b0;
        ptr          = '0;
        flush        = 1'b0;
        mem_ack      = 1'b0;
        mem_data     = '0;
        step();
        step();
        chk("reset_outputs", W'({valid, hit, busy, mem_req}), W'(0));
        chk("reset_out", out, '0);
        rst = 1'b0;
        step();

        do_miss(32'h10, 32'hDEADBEEF, 3, 1'b0, 1'b0, 32'd1);
        do_hit(32'h10, 32'hDEADBEEF, 32'd1);
        do_miss(32'h20, 32'hC0DE0020, 2, 1'b0, 1'b0, 32'd2);
        do_miss(32'h10, 32'hDEADBEEF, 1, 1'b0, 1'b0, 32'd3);
        do_miss(32'h11, 32'hC0DE0011, 1, 1'b0, 1'b0, 32'd4);
        do_miss(32'h12, 32'hC0DE0012, 2, 1'b0, 1'b0, 32'd5);

        // Back-to-back hits, one per cycle
        fetch_enable = 1'b1;
        ptr = 32'h10; q.push_back('{data: 32'hDEADBEEF, hit: 1'b1}); step();
        ptr = 32'h11; q.push_back('{data: 32'hC0DE0011, hit: 1'b1}); step();
        ptr = 32'h12; q.push_back('{data: 32'hC0DE0012, hit: 1'b1}); step();
        fetch_enable = 1'b0;
        chk("b2b_miss_count", miss_count, 32'd5);

        // Flush with a request on a cached address forces a miss
        do_miss(32'h10, 32'hDEADBEEF, 2, 1'b1, 1'b0, 32'd6);

        // Ack while idle is ignored
        mem_ack  = 1'b1;
        mem_data = 32'hBAD0BAD0;
        step();
        mem_ack  = 1'b0;
        step();
        chk("idle_ack_ignored", W'({busy, mem_req}), W'(0));
        chk("idle_ack_count", miss_count, 32'd6);

        do_miss(32'h11, 32'hC0DE0011, 1, 1'b0, 1'b0, 32'd7);
        // Flush on the ack edge: word delivered, line left invalid
        do_miss(32'h12, 32'hC0DE0012, 2, 1'b0, 1'b1, 32'd8);
        do_miss(32'h12, 32'hC0DE0012, 1, 1'b0, 1'b0, 32'd9);
        do_hit(32'h12, 32'hC0DE0012, 32'd9);

        // Reset mid-refill, then a late ack
        fetch_enable = 1'b1;
        ptr          = 32'h13;
        step();
        fetch_enable = 1'b0;
        chk("pre_reset_req", W'(mem_req), W'(1));
        step();
        rst = 1'b1;
        #1;
        chk("async_reset_flags", W'({valid, hit, busy, mem_req}), W'(0));
        chk("async_reset_addr", mem_addr, '0);
        chk("async_reset_count", miss_count, '0);
        chk("async_reset_out", out, '0);
        step();
        rst      = 1'b0;
        mem_ack  = 1'b1;
        mem_data = 32'h12345678;
        step();
        mem_ack  = 1'b0;
        mem_data = '0;
        step();
        chk("late_ack_ignored", W'({busy, mem_req}), W'(0));
        chk("late_ack_out", out, '0);
        do_miss(32'h10, 32'hDEADBEEF, 1, 1'b0, 1'b0, 32'd1);
        do_miss(32'h13, 32'hC0DE0013, 1, 1'b0, 1'b0, 32'd2);

        for (int i = 0; i < 8 && q.size() != 0; i++) step();
        chk("queue_drained", W'(q.size()), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
